// File: rtl/fm_dither_modulator_if.sv
// Sample/control bundle between the audio front end and the FM modulator core.
// master drives audio and control and observes the sine code; slave is the core.
interface fm_dither_modulator_if #(
    parameter int A = 8,
    parameter int L = 12,
    parameter int N = 18,
    parameter int D = 4
);
    logic                audio_valid;
    logic signed [A-1:0] audio;
    logic [N-1:0]        acc_inc;
    logic [L-1:0]        df_inc;
    logic [2:0]          dith_fact;
    logic                mute;
    logic [D-1:0]        rf;
    logic                phase_wrap;

    modport master (
        output audio_valid, audio, acc_inc, df_inc, dith_fact, mute,
        input  rf, phase_wrap
    );

    modport slave (
        input  audio_valid, audio, acc_inc, df_inc, dith_fact, mute,
        output rf, phase_wrap
    );
endinterface

// File: rtl/fm_dither_modulator.sv
// FM modulator core: sample latch, deviation scaling, phase accumulator,
// LFSR phase dither and quarter-wave sine lookup, one register per stage.
// The quarter-wave table holds the D=4, M=5 sine codes.
module fm_dither_modulator #(
    parameter int A = 8,
    parameter int L = 12,
    parameter int N = 18,
    parameter int M = 5,
    parameter int D = 4
) (
    input logic                  clk,
    input logic                  rst,
    fm_dither_modulator_if.slave bus
);
    localparam logic [15:0]  LFSR_SEED   = 16'hACE1;
    localparam logic [15:0]  LFSR_TAPS   = 16'hB400;
    localparam logic [M-2:0] QTR_POINT   = (M-1)'(2 ** (M - 2));
    localparam logic [M-1:0] HALF_POINT  = M'(2 ** (M - 1));
    localparam logic [D-1:0] FULL_SCALE  = {D{1'b1}};

    // Codes for addr 0..quarter period; the rest of the wave is folded onto these.
    localparam logic [D-1:0] SINE_QUARTER [0:8] = '{
        4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15, 4'd15
    };

    logic signed [A-1:0] a_reg;
    logic [N-1:0]        freq_word;
    logic [N-1:0]        phase;
    logic                phase_wrap_reg;
    logic [15:0]         lfsr;
    logic [M-1:0]        addr;
    logic [D-1:0]        rf_reg;

    logic signed [A+L-1:0] a_ext;
    logic signed [A+L-1:0] df_ext;
    logic signed [A+L-1:0] dev;
    logic signed [L:0]     dsc;
    logic [N-1:0]          dsc_ext;
    logic [N-1:0]          freq_next;
    logic [N:0]            acc_sum;
    logic [15:0]           lfsr_next;
    logic [N-M-1:0]        dith;
    logic [N-1:0]          dith_phase;
    logic [M-2:0]          raw_idx;
    logic [M-1:0]          fold_wide;
    logic [M-2:0]          q_idx;
    logic [D-1:0]          quarter_code;
    logic [D-1:0]          sine_next;
    logic                  unused_bits;

    // Deviation: signed audio times unsigned full-scale increment, scaled by 2^-(A-1).
    // The product always fits in A+L bits, so the truncated multiply is exact.
    assign a_ext     = {{L{a_reg[A-1]}}, a_reg};
    assign df_ext    = {{A{1'b0}}, bus.df_inc};
    assign dev       = a_ext * df_ext;
    assign dsc       = dev[A+L-1:A-1];
    assign dsc_ext   = {{(N-L-1){dsc[L]}}, dsc};
    assign freq_next = bus.acc_inc + (bus.mute ? '0 : dsc_ext);

    // Carry out of the accumulator becomes the wrap strobe.
    assign acc_sum   = {1'b0, phase} + {1'b0, freq_word};

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    // Dither is always below one address LSB, so it can only nudge addr up by one.
    assign dith       = (bus.dith_fact == 3'd0) ? '0
                      : (lfsr[N-M-1:0] >> (3'd7 - bus.dith_fact));
    assign dith_phase = phase + {{M{1'b0}}, dith};

    // Fold addr onto the quarter wave; the negative half mirrors around the
    // midpoint except at the zero crossing, where 7.5 rounds up to 8 on both halves.
    assign raw_idx      = addr[M-2:0];
    assign fold_wide    = HALF_POINT - {1'b0, raw_idx};
    assign q_idx        = (raw_idx > QTR_POINT) ? fold_wide[M-2:0] : raw_idx;
    assign quarter_code = SINE_QUARTER[q_idx];
    assign sine_next    = (!addr[M-1] || q_idx == '0) ? quarter_code
                                                      : FULL_SCALE - quarter_code;

    assign unused_bits = ^{dev[A-2:0], dith_phase[N-M-1:0]};

    // Pipeline stages 0..4 and the free-running LFSR; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg          <= '0;
            freq_word      <= '0;
            phase          <= '0;
            phase_wrap_reg <= 1'b0;
            lfsr           <= LFSR_SEED;
            addr           <= '0;
            rf_reg         <= '0;
        end else begin
            if (bus.audio_valid) begin
                a_reg <= bus.audio;
            end
            freq_word                 <= freq_next;
            {phase_wrap_reg, phase}   <= acc_sum;
            lfsr                      <= lfsr_next;
            addr                      <= dith_phase[N-1:N-M];
            rf_reg                    <= sine_next;
        end
    end

    assign bus.rf         = rf_reg;
    assign bus.phase_wrap = phase_wrap_reg;
endmodule

// File: doc/fm_dither_modulator.md
Name: fm_dither_modulator

Overview:
- Next-generation parametrised FM modulator core for the FM transmitter datapath.
- Sits between the audio CDC output (slow-to-fast, `clk` domain) and the DAC output gating.
- Adds these over the current modulator:
  - sample-strobe handshake
  - registered, pipelined deviation arithmetic
  - LFSR phase dithering driven by `dith_fact`
  - mute (unmodulated carrier)
  - a phase-wrap strobe for sync and test

Parameters:
- A, 8: audio sample width, signed two's complement.
- L, 12: frequency-deviation increment width, unsigned.
- N, 18: phase accumulator width, N-M ≤ 16.
- M, 5: sine address width.
- D, 4: DAC output width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- audio_valid  in  1  one-cycle strobe; audio is valid this cycle
- audio  in  A  signed audio sample
- acc_inc  in  N  carrier phase increment (F_C·2^N/F_S)
- df_inc  in  L  deviation increment for full-scale audio
- dith_fact  in  3  dither amplitude; 0 = off, 7 = max
- mute  in  1  1 = zero deviation (carrier only)
- rf  out  D  unsigned sine code to DAC
- phase_wrap  out  1  one-cycle strobe on accumulator carry-out

Behaviour:
- Reset (rst=1 at a clk edge):
  - a_reg=0, freq_word=0, phase=0, addr=0, rf=0, phase_wrap=0
  - lfsr=16'hACE1
  - Reset mid-operation discards the pipeline contents.
  - The first non-reset edge starts from these values.
- Stage 0, sample latch: a_reg <= audio when audio_valid=1, else hold. audio is ignored while audio_valid=0.
- Stage 1, frequency word:
  - dev = signed(a_reg) × unsigned(df_inc), full A+L bits, signed.
  - dsc = dev >>> (A-1), arithmetic shift, truncated to L+1 bits.
  - freq_word <= (acc_inc + sext_N(mute ? 0 : dsc)) mod 2^N.
  - Resulting deviation: +127 → +df_inc·127/128; -128 → -df_inc exactly.
- Stage 2, accumulator:
  - {carry, phase} <= phase + freq_word, N+1 bits.
  - phase wraps mod 2^N.
  - phase_wrap <= carry, registered the same cycle as phase.
- LFSR:
  - Galois, 16-bit, taps mask 16'hB400.
  - Each cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle, independent of any enable.
- Stage 3, dither and address:
  - dith = (dith_fact==0) ? 0 : lfsr[N-M-1:0] >> (7-dith_fact).
  - addr <= (phase + dith)[N-1:N-M], mod 2^N.
  - Dither never exceeds one address LSB.
- Stage 4, sine output:
  - rf <= round_half_up((2^D-1)/2 · (1 + sin(2π·addr/2^M))).
  - Implemented as a quarter-wave table with symmetry folding.
  - D=4, M=5 values: addr 0→8, 4→13, 8→15, 12→13, 16→8, 20→2, 24→0, 28→2.
- Latency:
  - acc_inc/df_inc/mute change → phase affected on the 2nd edge → rf on the 4th edge.
  - audio_valid → rf affected on the 5th edge.
- Simultaneous audio_valid and rst: rst wins.
- Mute asserted mid-sample: it takes effect at stage 1 on the next edge; a_reg is unaffected.
- rf is registered and glitch-free. The top level gates it with dac_ena/ena.

Test Plan:
- Carrier only:
  - Stimulus: acc_inc=32768, df_inc=0, dith_fact=0, after reset.
  - Required: rf cycles 8,13,15,13,8,2,0,2 with period 8; phase_wrap high once per 8 cycles.
- Deviation arithmetic:
  - Stimulus: acc_inc=32768, df_inc=1024.
  - audio=+127 strobed → freq_word=33784.
  - audio=-128 → freq_word=31744.
  - mute=1 → freq_word=32768.
  - audio changing while audio_valid=0 → no change.
- Wrap boundary:
  - Stimulus: acc_inc=2^18-1.
  - Required: phase decrements by 1 per cycle; phase_wrap=0 on the first accumulate from phase 0, then 1 on every following cycle.
- Dither:
  - acc_inc=0, dith_fact=7 → rf stays 8 (addr 0).
  - acc_inc=4096, dith_fact=0 → addr advances every 2 cycles exactly.
  - acc_inc=4096, dith_fact=7 → addr sequence differs from the undithered run but stays within ±1 of it.
  - LFSR first outputs after reset: 0xACE1 → 0xE270 → 0x7138 (check via hierarchy).
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while running with audio=+127.
  - Required: next cycle rf=0, phase=0, phase_wrap=0, lfsr=0xACE1; the carrier-only sequence then restarts identically to the first test.
